// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle mul/div sequencer.
// FSM state encoding, op codes, iteration count and ALU control codes.
package muldiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } muldiv_state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;
    localparam int   ITERS  = 32;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

endpackage

// File: rtl/alu_muldiv_seq_alu.sv
// 32-bit ALU: add, sub, and, or.
// Flags are {N, Z, C, V}; C is carry-out, i.e. "no borrow" on subtract.
module alu (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  ALUControl,
    output logic [31:0] Result,
    output logic [3:0]  ALUFlags
);

    logic [31:0] b_op;
    logic [32:0] sum;
    logic        arith;
    logic        n_f;
    logic        z_f;
    logic        c_f;
    logic        v_f;

    // Adder shared by add and sub (sub = A + ~B + 1), then result select and flags
    always_comb begin
        arith  = ~ALUControl[1];
        b_op   = ALUControl[0] ? ~B : B;
        sum    = {1'b0, A} + {1'b0, b_op} + {32'd0, ALUControl[0]};
        Result = sum[31:0];
        case (ALUControl)
            2'b10:   Result = A & B;
            2'b11:   Result = A | B;
            default: Result = sum[31:0];
        endcase
        n_f      = Result[31];
        z_f      = (Result == 32'd0);
        c_f      = arith & sum[32];
        v_f      = arith & ~(A[31] ^ B[31] ^ ALUControl[0])
                         & (A[31] ^ sum[31]);
        ALUFlags = {n_f, z_f, c_f, v_f};
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply / restoring divide sequencer.
// One iteration per clock through a single shared add/sub ALU.
module alu_muldiv_seq
    import muldiv_pkg::*;
#(
    parameter logic [31:0] DIV0_Q = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_hi,
    output logic [31:0] result_lo,
    output logic        div_by_zero
);

    localparam logic [4:0] LAST = 5'(ITERS - 1);

    muldiv_state_t state;
    logic [4:0]    cnt;
    logic          op_q;
    logic [31:0]   acc;
    logic [31:0]   shr;
    logic [31:0]   opnd;

    logic [31:0] alu_a;
    logic [1:0]  alu_ctl;
    logic [31:0] alu_res;
    logic [3:0]  alu_flags;
    logic        unused_flags;
    logic        carry;
    logic [31:0] t;
    logic [32:0] s;
    logic [31:0] acc_nxt;
    logic [31:0] shr_nxt;

    // acc holds hi (MUL) or remainder (DIV); shr holds lo or quotient;
    // opnd holds multiplicand or divisor
    alu u_alu (
        .A          (alu_a),
        .B          (opnd),
        .ALUControl (alu_ctl),
        .Result     (alu_res),
        .ALUFlags   (alu_flags)
    );

    // One shift-add or restoring-divide step computed from the current registers
    always_comb begin
        t            = {acc[30:0], shr[31]};
        alu_a        = (op_q == OP_DIV) ? t : acc;
        alu_ctl      = (op_q == OP_DIV) ? ALU_SUB : ALU_ADD;
        carry        = alu_flags[1];
        unused_flags = ^{alu_flags[3:2], alu_flags[0]};
        s            = shr[0] ? {carry, alu_res} : {1'b0, acc};
        if (op_q == OP_DIV) begin
            if (acc[31] | carry) begin
                acc_nxt = alu_res;
                shr_nxt = {shr[30:0], 1'b1};
            end else begin
                acc_nxt = t;
                shr_nxt = {shr[30:0], 1'b0};
            end
        end else begin
            acc_nxt = s[32:1];
            shr_nxt = {s[0], shr[31:1]};
        end
    end

    // Sequencer FSM, iteration counter, working registers and result latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_q        <= OP_MUL;
            acc         <= '0;
            shr         <= '0;
            opnd        <= '0;
            result_hi   <= '0;
            result_lo   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        cnt  <= '0;
                        acc  <= '0;
                        shr  <= (op == OP_DIV) ? A : B;
                        opnd <= (op == OP_DIV) ? B : A;
                        if (op == OP_DIV && B == 32'd0) begin
                            result_hi   <= A;
                            result_lo   <= DIV0_Q;
                            div_by_zero <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_nxt;
                    shr <= shr_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        result_hi   <= acc_nxt;
                        result_lo   <= shr_nxt;
                        div_by_zero <= 1'b0;
                        state       <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status decode straight from the state register
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq.
// Expected results are queued at issue and compared on done.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] result_hi;
    logic [31:0] result_lo;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   nchk  = 0;
    int   npass = 0;

    alu_muldiv_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .result_hi   (result_hi),
        .result_lo   (result_lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic o, input logic [31:0] a,
                                   input logic [31:0] b, input int c0);
        exp_t e;
        logic [63:0] p;
        if (o == 1'b0) begin
            p    = 64'(a) * 64'(b);
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
            e.cyc = c0 + 33;
        end else if (b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFFFFFF;
            e.dz = 1'b1;
            e.cyc = c0 + 1;
        end else begin
            e.hi = a % b;
            e.lo = a / b;
            e.dz = 1'b0;
            e.cyc = c0 + 33;
        end
        return e;
    endfunction

    // Compare each done pulse against the oldest queued expectation
    always @(posedge clk) begin
        #1;
        if (done) begin
            chk("busy_with_done", busy, 1);
            if (exp_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("result_hi", result_hi, e.hi);
                chk("result_lo", result_lo, e.lo);
                chk("div_by_zero", div_by_zero, e.dz);
            end
        end
    end

    task automatic issue(input logic o, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        exp_q.push_back(model(o, a, b, cyc));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("timeout", 64'(exp_q.size()), 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int c0;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {busy, done, div_by_zero, result_hi, result_lo}, 0);
        reset = 1'b0;
        @(negedge clk);

        // MUL 7*6 with busy window and held results
        chk("idle_busy", busy, 0);
        start = 1'b1;
        op    = 1'b0;
        A     = 32'd7;
        B     = 32'd6;
        c0    = cyc;
        exp_q.push_back(model(1'b0, 32'd7, 32'd6, c0));
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("busy_window", busy, (k >= 1 && k <= 33) ? 1 : 0);
        end
        chk("held_lo", result_lo, 32'h2A);
        chk("held_hi", result_hi, 0);
        drain();

        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        drain();
        issue(1'b1, 32'd100, 32'd7);
        drain();
        issue(1'b1, 32'hFFFFFFFF, 32'd1);
        drain();
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF);
        drain();
        issue(1'b1, 32'd5, 32'd0);
        drain();

        // Stray starts while busy, including in the done cycle
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        A     = 32'h1234;
        B     = 32'h5678;
        c0    = cyc;
        exp_q.push_back(model(1'b0, 32'h1234, 32'h5678, c0));
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k == 5 || k == 20 || k == 33);
            op    = 1'b1;
            A     = 32'd99;
            B     = 32'd0;
        end
        start = 1'b0;
        drain();
        chk("stray_result_lo", result_lo, 32'h1234 * 32'h5678);

        // Reset in the middle of a divide
        @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        A     = 32'd1000;
        B     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_midop",
            {busy, done, div_by_zero, result_hi, result_lo}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(1'b0, 32'd3, 32'd3);
        drain();
        chk("after_reset_lo", result_lo, 9);

        // Random operations against the 64-bit reference
        for (int i = 0; i < 200; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: ra = $urandom_range(0, 255);
                default: ;
            endcase
            issue(1'(($urandom_range(0, 1))), ra, rb);
            drain();
        end

        chk("queue_empty", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
